// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response bundle between the fetch controller and memory.
// The fetch controller drives the request side and the memory drives grant and response.
interface fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding memory request, a small FIFO of
// fetched {pc, instr} pairs feeding IF/ID, and redirect-driven flushing.
module fetch_ctrl #(
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [31:0]         pc,
  output logic [31:0]         pc_next,
  output logic                pc_en,
  fetch_ctrl_if.master        imem,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc,
  input  logic                stall_id,
  output logic                if_valid,
  output logic [31:0]         if_pc,
  output logic [31:0]         if_instr
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {ISSUE, WAIT, FLUSH} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        req_pc_q, req_pc_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [31:0]        pc_mem    [BUF_DEPTH];
  logic [31:0]        instr_mem [BUF_DEPTH];

  logic push, pop, flush, full;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full     = (count_q == CNT_W'(BUF_DEPTH));
  assign if_valid = reset_n && (count_q != '0);
  assign pop      = if_valid && !stall_id;
  assign if_pc    = pc_mem[rd_ptr_q];
  assign if_instr = instr_mem[rd_ptr_q];

  always_comb begin
    // NOTE: every output and next-state gets a default first so no path infers a latch.
    state_d        = state_q;
    req_pc_d       = req_pc_q;
    pc_en          = 1'b0;
    pc_next        = pc + 32'd4;
    imem.imem_req  = 1'b0;
    imem.imem_addr = pc;
    push           = 1'b0;
    flush          = 1'b0;

    if (reset_n) begin
      if (redirect_valid) begin
        pc_en   = 1'b1;
        pc_next = redirect_pc;
        flush   = 1'b1;
        // A response landing together with the redirect is dropped right here.
        if (state_q == WAIT) state_d = imem.imem_rvalid ? ISSUE : FLUSH;
      end else begin
        unique case (state_q)
          ISSUE: begin
            if (!full) begin
              imem.imem_req = 1'b1;
              if (imem.imem_gnt) begin
                pc_en    = 1'b1;
                req_pc_d = pc;
                state_d  = WAIT;
              end
            end
          end
          WAIT: begin
            if (imem.imem_rvalid) begin
              push    = 1'b1;
              state_d = ISSUE;
            end
          end
          FLUSH:   if (imem.imem_rvalid) state_d = ISSUE;
          default: state_d = ISSUE;
        endcase
      end
    end
  end

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ISSUE;
      count_q  <= '0;
      req_pc_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      req_pc_q <= req_pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: buffer storage is not reset; count_q gates its visibility, so stale contents are harmless.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= req_pc_q;
      instr_mem[wr_ptr_q] <= imem.imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: stimulus pushes expected {pc, instr} into a scoreboard
// queue, and a monitor pops and compares whenever IF/ID consumes an instruction.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        pc_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall_id;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  fetch_ctrl_if imem_if ();

  fetch_ctrl #(.BUF_DEPTH(2)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pc             (pc),
    .pc_next        (pc_next),
    .pc_en          (pc_en),
    .imem           (imem_if),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall_id       (stall_id),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check(name, {31'b0, act}, {31'b0, exp});
  endtask

  // Monitor: a pop happens whenever IF/ID sees a valid instruction and is not stalled.
  always @(negedge clk) begin
    #2;
    if (if_valid === 1'b1 && stall_id === 1'b0) begin
      if (exp_q.size() == 0) begin
        check_bit("spurious_if_valid", if_valid, 1'b0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("sb_if_pc", if_pc, e[63:32]);
        check("sb_if_instr", if_instr, e[31:0]);
      end
    end
  end

  // Advance one clock; the bench plays the external PC register.
  task automatic step();
    logic        en_s;
    logic [31:0] nx_s;
    #1;
    en_s = pc_en;
    nx_s = pc_next;
    @(posedge clk);
    #1;
    if (en_s) pc = nx_s;
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [31:0] start_pc);
    imem_if.imem_gnt    = 1'b0;
    imem_if.imem_rvalid = 1'b0;
    redirect_valid      = 1'b0;
    stall_id            = 1'b0;
    step();
    check("sb_drained", exp_q.size(), 0);
    reset_n = 1'b0;
    pc      = start_pc;
    #1;
    check_bit("rst_imem_req", imem_if.imem_req, 1'b0);
    check_bit("rst_pc_en", pc_en, 1'b0);
    check_bit("rst_if_valid", if_valid, 1'b0);
    check("rst_pc_next", pc_next, start_pc + 32'd4);
    step();
    step();
    reset_n = 1'b1;
  endtask

  // Grant one request in ISSUE, then return a one-cycle response in WAIT.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] nxt, input logic [31:0] data);
    imem_if.imem_gnt    = 1'b1;
    imem_if.imem_rvalid = 1'b0;
    #1;
    check_bit("fetch_req", imem_if.imem_req, 1'b1);
    check("fetch_addr", imem_if.imem_addr, addr);
    check_bit("fetch_pc_en", pc_en, 1'b1);
    check("fetch_pc_next", pc_next, nxt);
    step();
    imem_if.imem_rvalid = 1'b1;
    imem_if.imem_rdata  = data;
    #1;
    check_bit("wait_no_req", imem_if.imem_req, 1'b0);
    exp_q.push_back({addr, data});
    step();
    imem_if.imem_rvalid = 1'b0;
    imem_if.imem_gnt    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

  initial begin
    reset_n             = 1'b0;
    pc                  = 32'h0;
    redirect_valid      = 1'b0;
    redirect_pc         = 32'h0;
    stall_id            = 1'b0;
    imem_if.imem_gnt    = 1'b0;
    imem_if.imem_rvalid = 1'b0;
    imem_if.imem_rdata  = 32'h0;
    @(negedge clk);

    // First fetch after reset release.
    do_reset(32'h0);
    fetch(32'h0, 32'h4, 32'h00000013);
    #1;
    check_bit("first_if_valid", if_valid, 1'b1);
    check("first_if_pc", if_pc, 32'h0);
    check("first_if_instr", if_instr, 32'h00000013);
    step();

    // Fill the buffer under stall, then drain in order.
    do_reset(32'h0);
    stall_id = 1'b1;
    fetch(32'h0, 32'h4, 32'h00000013);
    fetch(32'h4, 32'h8, 32'h00100093);
    imem_if.imem_gnt = 1'b1;
    #1;
    check_bit("full_no_req", imem_if.imem_req, 1'b0);
    check("stall_if_pc", if_pc, 32'h0);
    step();
    #1;
    check_bit("full_no_req_hold", imem_if.imem_req, 1'b0);
    check("stall_hold_pc", if_pc, 32'h0);
    check("stall_hold_instr", if_instr, 32'h00000013);
    check("stall_pc_reg", pc, 32'h8);
    stall_id         = 1'b0;
    imem_if.imem_gnt = 1'b0;
    step();
    #1;
    check("drain_second_pc", if_pc, 32'h4);
    step();
    #1;
    check_bit("drain_empty", if_valid, 1'b0);

    // Redirect in WAIT; response arrives two cycles later in FLUSH.
    do_reset(32'h0);
    imem_if.imem_gnt = 1'b1;
    step();
    imem_if.imem_gnt = 1'b0;
    redirect_valid   = 1'b1;
    redirect_pc      = 32'h100;
    #1;
    check_bit("redir_pc_en", pc_en, 1'b1);
    check("redir_pc_next", pc_next, 32'h100);
    check_bit("redir_no_req", imem_if.imem_req, 1'b0);
    step();
    redirect_valid   = 1'b0;
    imem_if.imem_gnt = 1'b1;
    #1;
    check_bit("flush_no_req", imem_if.imem_req, 1'b0);
    step();
    imem_if.imem_rvalid = 1'b1;
    imem_if.imem_rdata  = 32'hDEADBEEF;
    #1;
    check_bit("flush_rvalid_no_req", imem_if.imem_req, 1'b0);
    step();
    imem_if.imem_rvalid = 1'b0;
    imem_if.imem_gnt    = 1'b0;
    #1;
    check_bit("flush_dropped", if_valid, 1'b0);
    check_bit("post_flush_req", imem_if.imem_req, 1'b1);
    check("post_flush_addr", imem_if.imem_addr, 32'h100);
    step();

    // Redirect and response in the same WAIT cycle.
    do_reset(32'h0);
    imem_if.imem_gnt = 1'b1;
    step();
    imem_if.imem_gnt    = 1'b0;
    redirect_valid      = 1'b1;
    redirect_pc         = 32'h200;
    imem_if.imem_rvalid = 1'b1;
    imem_if.imem_rdata  = 32'hBADBAD00;
    #1;
    check_bit("redir_rv_pc_en", pc_en, 1'b1);
    check("redir_rv_pc_next", pc_next, 32'h200);
    step();
    redirect_valid      = 1'b0;
    imem_if.imem_rvalid = 1'b0;
    #1;
    check_bit("redir_rv_dropped", if_valid, 1'b0);
    check("redir_rv_addr", imem_if.imem_addr, 32'h200);
    fetch(32'h200, 32'h204, 32'h00000033);

    // PC wrap at the top of the address space.
    do_reset(32'hFFFFFFFC);
    fetch(32'hFFFFFFFC, 32'h0, 32'hAAAA0013);
    check("wrap_pc_reg", pc, 32'h0);

    // Reset while WAIT, stale response after release.
    do_reset(32'h0);
    imem_if.imem_gnt = 1'b1;
    step();
    imem_if.imem_gnt = 1'b0;
    reset_n          = 1'b0;
    #1;
    check_bit("midrst_req", imem_if.imem_req, 1'b0);
    check_bit("midrst_pc_en", pc_en, 1'b0);
    check("midrst_pc_next", pc_next, 32'h8);
    step();
    reset_n             = 1'b1;
    imem_if.imem_rvalid = 1'b1;
    imem_if.imem_rdata  = 32'h12345678;
    #1;
    check_bit("midrst_reissue", imem_if.imem_req, 1'b1);
    check("midrst_addr", imem_if.imem_addr, 32'h4);
    step();
    imem_if.imem_rvalid = 1'b0;
    #1;
    check_bit("midrst_ignored", if_valid, 1'b0);
    fetch(32'h4, 32'h8, 32'h00200113);

    // Back-to-back fetches with no stall: one instruction every two cycles.
    do_reset(32'h40);
    fetch(32'h40, 32'h44, 32'h00300193);
    fetch(32'h44, 32'h48, 32'h00400213);
    fetch(32'h48, 32'h4C, 32'h00500293);

    step();
    step();
    check("final_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter: BUF_DEPTH, 2, number of fetched-instruction buffer entries; legal values >= 2.
REQ-002 Ports: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Ports: reset_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 Ports: pc  input  32  current fetch PC, from the external PC register.
REQ-005 Ports: pc_next  output  32  next value for the PC register.
REQ-006 Ports: pc_en  output  1  PC register load enable; PC loads pc_next on the same clock edge.
REQ-007 Ports: imem_req  output  1  instruction memory request valid.
REQ-008 Ports: imem_addr  output  32  request address.
REQ-009 Ports: imem_gnt  input  1  memory accepts the request this cycle (imem_req && imem_gnt).
REQ-010 Ports: imem_rvalid  input  1  response valid; arrives one or more cycles after grant.
REQ-011 Ports: imem_rdata  input  32  response instruction word.
REQ-012 Ports: redirect_valid  input  1  branch/jump taken in EX; flushes fetch.
REQ-013 Ports: redirect_pc  input  32  redirect target address.
REQ-014 Ports: stall_id  input  1  ID stage cannot accept an instruction this cycle.
REQ-015 Ports: if_valid, if_pc[31:0], if_instr[31:0]  output  instruction offered to IF/ID.

Function
REQ-016 FSM states SHALL be ISSUE (no request outstanding), WAIT (one granted request outstanding), and FLUSH (outstanding response to discard).
REQ-017 At most one granted request SHALL be outstanding.
REQ-018 In ISSUE, imem_req SHALL be 1, with imem_addr = pc, when count + 1 <= BUF_DEPTH and redirect_valid = 0.
REQ-019 When a request is granted: pc_en = 1, pc_next = pc + 4 (modulo 2^32, 0xFFFFFFFC wraps to 0x0), req_pc <= pc, and the next state is WAIT.
REQ-020 In WAIT, on imem_rvalid: push {req_pc, imem_rdata} into the buffer, then go to ISSUE. A new request SHALL NOT be issued in the same cycle.
REQ-021 The buffer SHALL be a FIFO of BUF_DEPTH entries. if_valid = (count != 0); if_pc and if_instr come from the head entry.
REQ-022 Pop SHALL occur when if_valid && !stall_id. Push and pop in the same cycle SHALL leave count unchanged.
REQ-023 Outputs SHALL hold stable while if_valid && stall_id.
REQ-024 redirect_valid has highest priority. In that cycle: pc_en = 1, pc_next = redirect_pc, imem_req = 0, and count <= 0.
REQ-025 Redirect next state: from WAIT without imem_rvalid, go to FLUSH; from WAIT with imem_rvalid, go to ISSUE and discard the response; from ISSUE, stay in ISSUE; from FLUSH, stay in FLUSH.
REQ-026 In FLUSH, imem_req SHALL be 0. On imem_rvalid the response SHALL be discarded and the next state is ISSUE.
REQ-027 Outside REQ-019 and REQ-024: pc_en = 0 and pc_next = pc + 4.
REQ-028 imem_rvalid in ISSUE SHALL be ignored.
REQ-029 With BUF_DEPTH = 2, back-to-back single-cycle memory and stall_id = 0 SHALL give one instruction every 2 cycles.

Reset
REQ-030 On a rising clk edge with reset_n = 0: state <= ISSUE, count <= 0, req_pc <= 0, and FIFO pointers <= 0.
REQ-031 While reset_n = 0: imem_req = 0, pc_en = 0, if_valid = 0, and pc_next = pc + 4.
REQ-032 Reset mid-operation SHALL abandon any outstanding request. A later imem_rvalid arriving in ISSUE is ignored per REQ-028.

Verification
REQ-033 Reset release with pc = 0x0, gnt = 1, one-cycle response 0x00000013 -> imem_addr = 0x0, pc_en = 1, pc_next = 0x4, and the following cycle gives if_valid = 1, if_pc = 0x0, if_instr = 0x00000013.
REQ-034 stall_id = 1 held while 2 instructions (pc 0x0, 0x4) are fetched -> count = 2, imem_req = 0, and if_pc holds at 0x0. On release, 0x0 then 0x4 pop on consecutive cycles.
REQ-035 redirect_valid = 1, redirect_pc = 0x100 while in WAIT, then rvalid 2 cycles later with 0xDEADBEEF -> pc_en = 1 and pc_next = 0x100; the response is dropped, if_valid stays 0, and the next request has imem_addr = 0x100.
REQ-036 redirect_valid and imem_rvalid in the same WAIT cycle -> the response is discarded, state goes to ISSUE, and the next imem_addr = redirect_pc.
REQ-037 pc = 0xFFFFFFFC granted -> pc_next = 0x00000000.
REQ-038 reset_n = 0 asserted during WAIT, then rvalid after release -> if_valid stays 0 and the first request after release uses the current pc.
